// File: rtl/video_timing.sv
// Purpose: raster timing generator with latency-aligned sync/de and colour gating (optional: VIDEO_TEST_PATTERN_EN).
// Latency: x/y coords and copy_start are immediate; hsync/vsync/de/pattern are delayed by PIPE_LATENCY clocks.
// Backpressure: none; free-running counters advance every pixel_clk, the renderer must keep up.
module video_timing #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int PIPE_LATENCY = 6,
  parameter int COORD_WIDTH  = 16,
  parameter bit SYNC_ACTIVE  = 1'b0
) (
  input  logic                   pixel_clk,
  input  logic                   reset,
`ifdef VIDEO_TEST_PATTERN_EN
  input  logic                   test_pattern,
`endif
  input  logic [15:0]            color_in,
  output logic [COORD_WIDTH-1:0] x_coord,
  output logic [COORD_WIDTH-1:0] y_coord,
  output logic                   copy_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [4:0]             r,
  output logic [5:0]             g,
  output logic [4:0]             b,
  output logic [15:0]            frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  // One extra count of headroom so the sync end bound fits even with a zero back porch.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [15:0]   frame_count_q, frame_count_d;
  logic          copy_start_q, copy_start_d;
  logic          h_wrap, v_wrap;
  logic          raw_active, raw_hs, raw_vs;

  // Delay lines hold "asserted" flags; 0 means inactive, so clearing them deasserts everything.
  logic [PIPE_LATENCY-1:0] act_pipe_q, act_pipe_d;
  logic [PIPE_LATENCY-1:0] hs_pipe_q, hs_pipe_d;
  logic [PIPE_LATENCY-1:0] vs_pipe_q, vs_pipe_d;

  // Counter, frame and vblank-pulse next-state logic.
  always_comb begin
    h_wrap        = (h_cnt_q == HW'(H_TOTAL - 1));
    v_wrap        = (v_cnt_q == VW'(V_TOTAL - 1));
    h_cnt_d       = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d       = v_cnt_q;
    frame_count_d = frame_count_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + 1'b1;
      if (v_wrap) frame_count_d = frame_count_q + 16'd1;
    end
    // Registered pulse lands on the same clock the counters show line V_VISIBLE, pixel 0.
    copy_start_d = (h_cnt_d == '0) && (v_cnt_d == VW'(V_VISIBLE));
  end

  // Raw timing decode from the live counters.
  always_comb begin
    raw_active = (h_cnt_q < HW'(H_VISIBLE)) && (v_cnt_q < VW'(V_VISIBLE));
    raw_hs     = (h_cnt_q >= HW'(H_VISIBLE + H_FRONT)) &&
                 (h_cnt_q <  HW'(H_VISIBLE + H_FRONT + H_SYNC));
    raw_vs     = (v_cnt_q >= VW'(V_VISIBLE + V_FRONT)) &&
                 (v_cnt_q <  VW'(V_VISIBLE + V_FRONT + V_SYNC));
  end

  // Shift the raw flags down the renderer-matching delay lines.
  always_comb begin
    act_pipe_d    = act_pipe_q;
    hs_pipe_d     = hs_pipe_q;
    vs_pipe_d     = vs_pipe_q;
    act_pipe_d[0] = raw_active;
    hs_pipe_d[0]  = raw_hs;
    vs_pipe_d[0]  = raw_vs;
    for (int i = 1; i < PIPE_LATENCY; i++) begin
      act_pipe_d[i] = act_pipe_q[i-1];
      hs_pipe_d[i]  = hs_pipe_q[i-1];
      vs_pipe_d[i]  = vs_pipe_q[i-1];
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_count_q <= '0;
      copy_start_q  <= 1'b0;
      act_pipe_q    <= '0;
      hs_pipe_q     <= '0;
      vs_pipe_q     <= '0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_count_q <= frame_count_d;
      copy_start_q  <= copy_start_d;
      act_pipe_q    <= act_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
    end
  end

  // Coordinates are zero-extended; COORD_WIDTH must cover the counter widths.
  assign x_coord     = {{(COORD_WIDTH - HW){1'b0}}, h_cnt_q};
  assign y_coord     = {{(COORD_WIDTH - VW){1'b0}}, v_cnt_q};
  assign copy_start  = copy_start_q;
  assign frame_count = frame_count_q;
  assign de          = act_pipe_q[PIPE_LATENCY-1];
  assign hsync       = hs_pipe_q[PIPE_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync       = vs_pipe_q[PIPE_LATENCY-1] ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  logic [15:0] pix_color;

`ifdef VIDEO_TEST_PATTERN_EN
  logic [15:0] pat_pipe_q [PIPE_LATENCY];
  logic [15:0] pat_pipe_d [PIPE_LATENCY];

  // Pattern colour follows the same delay as de so it lines up with the renderer stream.
  always_comb begin
    pat_pipe_d    = pat_pipe_q;
    pat_pipe_d[0] = {x_coord[7:3], y_coord[7:2], x_coord[7:3]};
    for (int i = 1; i < PIPE_LATENCY; i++) pat_pipe_d[i] = pat_pipe_q[i-1];
  end

  // Pattern delay line registers.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) pat_pipe_q[i] <= '0;
    end else begin
      pat_pipe_q <= pat_pipe_d;
    end
  end

  assign pix_color = test_pattern ? pat_pipe_q[PIPE_LATENCY-1] : color_in;
`else
  assign pix_color = color_in;
`endif

  // Colour gating: blank outside the display window, no register in the path.
  always_comb begin
    r = '0;
    g = '0;
    b = '0;
    if (de) begin
      r = pix_color[15:11];
      g = pix_color[10:5];
      b = pix_color[4:0];
    end
  end

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing on a reduced raster (32x15 total, 16x8 visible, latency 6).
// Spot-vector table plus a per-cycle reference model feed a scoreboard queue.
// A mid-frame reset sequence checks the restart and the de hold-off.
module tb_video_timing;

  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 8, VF = 2, VS = 2, VB = 3;
  localparam int L  = 6;
  localparam int CW = 16;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic          pixel_clk = 1'b0;
  logic          reset     = 1'b1;
  logic [15:0]   color_in  = '0;
  logic [CW-1:0] x_coord, y_coord;
  logic          copy_start, hsync, vsync, de;
  logic [4:0]    r;
  logic [5:0]    g;
  logic [4:0]    b;
  logic [15:0]   frame_count;

  video_timing #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIPE_LATENCY(L), .COORD_WIDTH(CW), .SYNC_ACTIVE(1'b0)
  ) dut (
    .pixel_clk(pixel_clk),
    .reset(reset),
`ifdef VIDEO_TEST_PATTERN_EN
    .test_pattern(1'b0),
`endif
    .color_in(color_in),
    .x_coord(x_coord),
    .y_coord(y_coord),
    .copy_start(copy_start),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .r(r),
    .g(g),
    .b(b),
    .frame_count(frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    string       tag;
    logic [15:0] x, y;
    logic        de, hs, vs, cs;
    logic [15:0] rgb, fc;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [15:0] color;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_pass = 0;
  int   n_total = 0;

  function automatic vec_t mkvec(int cyc, logic [15:0] color, int x, int y,
                                 logic de_e, logic hs_e, logic vs_e, logic cs_e,
                                 logic [15:0] rgb_e, int fc_e);
    vec_t v;
    v.cyc = cyc; v.color = color;
    v.e.tag = $sformatf("vec@%0d", cyc);
    v.e.x = 16'(x); v.e.y = 16'(y);
    v.e.de = de_e; v.e.hs = hs_e; v.e.vs = vs_e; v.e.cs = cs_e;
    v.e.rgb = rgb_e; v.e.fc = 16'(fc_e);
    return v;
  endfunction

  // Reference: outputs as a pure function of clocks since reset.
  function automatic exp_t model(int n, logic [15:0] color);
    exp_t e;
    int   m, hm, vm;
    logic as_h, as_v;
    e.tag = $sformatf("model@%0d", n);
    e.x   = 16'(n % HT);
    e.y   = 16'((n / HT) % VT);
    e.fc  = 16'(n / (HT * VT));
    e.cs  = (e.x == 0) && (e.y == 16'(VV));
    e.de = 1'b0; as_h = 1'b0; as_v = 1'b0;
    if (n >= L) begin
      m  = n - L;
      hm = m % HT;
      vm = (m / HT) % VT;
      e.de = (hm < HV) && (vm < VV);
      as_h = (hm >= HV + HF) && (hm < HV + HF + HS);
      as_v = (vm >= VV + VF) && (vm < VV + VF + VS);
    end
    e.hs  = as_h ? 1'b0 : 1'b1;
    e.vs  = as_v ? 1'b0 : 1'b1;
    e.rgb = e.de ? color : 16'h0000;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    logic [15:0] rgb_a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      rgb_a = {r, g, b};
      n_total++;
      if (x_coord === e.x && y_coord === e.y && de === e.de && hsync === e.hs &&
          vsync === e.vs && copy_start === e.cs && rgb_a === e.rgb && frame_count === e.fc)
        n_pass++;
      else
        $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b cs=%b rgb=%h fc=%0d, want x=%0d y=%0d de=%b hs=%b vs=%b cs=%b rgb=%h fc=%0d",
                 e.tag, x_coord, y_coord, de, hsync, vsync, copy_start, rgb_a, frame_count,
                 e.x, e.y, e.de, e.hs, e.vs, e.cs, e.rgb, e.fc);
    end
  endtask

  // Drive one cycle's colour, queue expectations, compare, then advance a clock.
  task automatic run_cycle(int n, logic use_tbl);
    logic [15:0] col;
    col = 16'($urandom);
    if (use_tbl)
      for (int i = 0; i < tbl.size(); i++)
        if (tbl[i].cyc == n) begin
          col = tbl[i].color;
          sb_q.push_back(tbl[i].e);
        end
    color_in = col;
    sb_q.push_back(model(n, col));
    #1;
    check_pop();
  endtask

  initial begin
    // Spot vectors derived by hand for the reduced raster.
    tbl.push_back(mkvec(  0, 16'hF800,  0,  0, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec(  5, 16'hF800,  5,  0, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec(  6, 16'hF800,  6,  0, 1, 1, 1, 0, 16'hF800, 0));
    tbl.push_back(mkvec( 21, 16'h07E0, 21,  0, 1, 1, 1, 0, 16'h07E0, 0));
    tbl.push_back(mkvec( 22, 16'hFFFF, 22,  0, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec( 25, 16'hFFFF, 25,  0, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec( 26, 16'hFFFF, 26,  0, 0, 0, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec( 31, 16'hFFFF, 31,  0, 0, 0, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec( 32, 16'hFFFF,  0,  1, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec( 38, 16'h001F,  6,  1, 1, 1, 1, 0, 16'h001F, 0));
    tbl.push_back(mkvec(256, 16'hFFFF,  0,  8, 0, 1, 1, 1, 16'h0000, 0));
    tbl.push_back(mkvec(257, 16'hFFFF,  1,  8, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec(326, 16'hFFFF,  6, 10, 0, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mkvec(389, 16'hFFFF,  5, 12, 0, 1, 0, 0, 16'h0000, 0));
    tbl.push_back(mkvec(390, 16'hFFFF,  6, 12, 0, 1, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec(479, 16'hFFFF, 31, 14, 0, 0, 1, 0, 16'h0000, 0));
    tbl.push_back(mkvec(480, 16'hFFFF,  0,  0, 0, 1, 1, 0, 16'h0000, 1));
    tbl.push_back(mkvec(486, 16'hF800,  6,  0, 1, 1, 1, 0, 16'hF800, 1));

    reset = 1'b1;
    repeat (3) @(posedge pixel_clk);
    #1;
    reset = 1'b0;

    // Two frames' worth from reset; stop in the second frame at x=10, y=3.
    for (int n = 0; n <= 586; n++) begin
      run_cycle(n, 1'b1);
      if (n == 586) begin
        if (x_coord !== 16'd10 || y_coord !== 16'd3) begin
          n_total++;
          $display("FAIL reset_point: got x=%0d y=%0d, want x=10 y=3", x_coord, y_coord);
        end
        reset = 1'b1;
      end
      @(posedge pixel_clk);
      #1;
    end
    reset = 1'b0;

    // Mid-frame reset: counters restart at zero and de holds off for L clocks.
    for (int k = 0; k <= L; k++) begin
      exp_t h;
      h.tag = $sformatf("rst_seq@%0d", k);
      h.x = 16'(k); h.y = 16'd0; h.fc = 16'd0;
      h.de = (k == L); h.hs = 1'b1; h.vs = 1'b1; h.cs = 1'b0;
      h.rgb = (k == L) ? 16'hF800 : 16'h0000;
      color_in = 16'hF800;
      sb_q.push_back(h);
      sb_q.push_back(model(k, 16'hF800));
      #1;
      check_pop();
      @(posedge pixel_clk);
      #1;
    end
    for (int n = L + 1; n < 48; n++) begin
      run_cycle(n, 1'b0);
      @(posedge pixel_clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/video_timing.md
VIDEO_TIMING -- requirements
Module: video_timing

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT 16, H_SYNC 96, H_BACK 48, giving horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2, V_BACK 33, giving vertical timing in lines.
REQ-004 SHALL have parameter PIPE_LATENCY, default 6, the downstream renderer latency in clocks; legal range 1..15.
REQ-005 SHALL have parameter COORD_WIDTH, default 16, the coordinate output width.
REQ-006 SHALL have parameter SYNC_ACTIVE, default 0, the asserted level of hsync and vsync.
REQ-007 pixel_clk  input  1  pixel clock.
REQ-008 reset  input  1  synchronous, active-high.
REQ-009 x_coord  output  COORD_WIDTH  current horizontal counter, fed to the renderer.
REQ-010 y_coord  output  COORD_WIDTH  current vertical counter, fed to the renderer.
REQ-011 copy_start  output  1  one-clock pulse at the start of vertical blank.
REQ-012 color_in  input  16  RGB565 colour returned by the renderer, PIPE_LATENCY clocks after the matching coordinates.
REQ-013 hsync, vsync  output  1 each  latency-aligned sync outputs.
REQ-014 de  output  1  latency-aligned display enable.
REQ-015 r, g, b  output  5 / 6 / 5  pixel colour; zero when de=0.
REQ-016 frame_count  output  16  count of completed frames.

Function
REQ-017 Terms: H_TOTAL = sum of the four H parameters; V_TOTAL = sum of the four V parameters.
REQ-018 h_cnt SHALL increment every clock and wrap from H_TOTAL-1 to 0.
REQ-019 v_cnt SHALL increment only on the clock where h_cnt wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-020 x_coord/y_coord SHALL equal h_cnt/v_cnt directly, zero-extended to COORD_WIDTH, with no added delay.
REQ-021 Raw active SHALL be h_cnt<H_VISIBLE and v_cnt<V_VISIBLE.
REQ-022 Raw hsync SHALL be asserted for H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC.
REQ-023 Raw vsync SHALL be asserted for V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC, for whole lines.
REQ-024 Raw active, hsync and vsync SHALL each pass through a PIPE_LATENCY-stage register delay line before driving de/hsync/vsync.
REQ-025 Sync outputs SHALL take level SYNC_ACTIVE when asserted and ~SYNC_ACTIVE otherwise.
REQ-026 {r,g,b} SHALL equal color_in[15:11], color_in[10:5], color_in[4:0] registered-free (combinational) when de=1, else 0.
REQ-027 copy_start SHALL be registered and high for exactly one clock, on the clock where h_cnt=0 and v_cnt=V_VISIBLE; it is not delayed.
REQ-028 frame_count SHALL increment, modulo 2^16, on the clock where both h_cnt and v_cnt wrap to 0.
REQ-029 Reaching the end of the last line SHALL yield h_cnt=0 and v_cnt=0 on the next clock, with no idle cycle.

Reset
REQ-030 Reset SHALL set h_cnt, v_cnt and frame_count to 0, and copy_start to 0.
REQ-031 Reset SHALL clear every delay-line stage to inactive: de=0 and syncs deasserted.
REQ-032 Reset asserted mid-frame SHALL take effect on the next edge.
REQ-033 After reset, de SHALL stay 0 for PIPE_LATENCY clocks before reflecting the counters.

Configuration
REQ-034 With VIDEO_TEST_PATTERN_EN defined, an input test_pattern (1 bit) SHALL exist, and the following SHALL apply:
- a pattern colour {h_cnt[7:3], v_cnt[7:2], h_cnt[7:3]} SHALL be delayed PIPE_LATENCY stages;
- this delayed pattern SHALL replace color_in in REQ-026 while test_pattern=1.
REQ-035 Without VIDEO_TEST_PATTERN_EN, there SHALL be no test_pattern port and no pattern delay line, and the behaviour SHALL be exactly as REQ-026.

Verification (default parameters; cycle 0 = first clock after reset released)
REQ-036 Counters: x_coord SHALL be 799 at cycle 799 and 0 at cycle 800; y_coord SHALL go from 0 to 1 at cycle 800.
REQ-037 Display enable: de SHALL be 0 for cycles 0-5, 1 for cycles 6-645, and 0 at cycle 646.
REQ-038 Horizontal sync: hsync SHALL be 0 for cycles 662-757 (96 clocks) and 1 at cycles 661 and 758.
REQ-039 Vertical blank and sync:
- copy_start SHALL be high only at cycle 384000;
- vsync SHALL be 0 from cycle 392006 through 393605;
- frame_count SHALL be 1 at cycle 420000.
REQ-040 Colour gating: color_in=0xF800 SHALL yield r=31, g=0, b=0 while de=1 and r=g=b=0 while de=0.
REQ-041 Mid-frame reset: reset pulsed at x_coord=300, y_coord=7 SHALL give x=y=0 and frame_count=0 on the next clock, then de=0 for 6 clocks.
